uart_link_fabric: RTL and testbench

Synthesizable N-port UART line fabric that replaces the fixed two-device tx/rx crossover in the testbench top.
- Each port's rx is driven from a run-time-selected tx, through a programmable propagation delay.
- Supports per-link single-window fault injection and per-link start-bit counting.
- Sits between the uart_if instances of all device agent BFMs; one clock domain (pclk).

---
 rtl/uart_link_pkg.sv | 35 +++
 rtl/uart_link_lane.sv | 78 +++++++
 rtl/uart_link_fabric.sv | 193 +++++++++++++++++++
 tb/tb_uart_link_fabric.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_link_pkg.sv
// rtl/uart_link_pkg.sv - shared types and helpers for the UART link fabric
package uart_link_pkg;

  // Width of a source selector: one code beyond the last port means disconnected.
  function automatic int sel_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of a delay field able to hold 0..max_delay.
  function automatic int dly_width(input int max_delay);
    return $clog2(max_delay + 1);
  endfunction

  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_WAIT,
    CFG_APPLY
  } cfg_state_e;

  typedef enum logic [1:0] {
    INJ_IDLE,
    INJ_ARMED,
    INJ_OFFSET,
    INJ_ACTIVE
  } inj_state_e;

  // Crossover pairing i <-> i^1; an unpaired last port loops back to itself.
  function automatic int default_route(input int idx, input int n);
    if ((n % 2 == 1) && (idx == n - 1)) begin
      return idx;
    end
    return idx ^ 1;
  endfunction

endpackage

// File: rtl/uart_link_lane.sv
// rtl/uart_link_lane.sv - one rx lane: delay line, idle tracking, start detect, frame count
module uart_link_lane
  import uart_link_pkg::*;
#(
  parameter int MAX_DELAY   = 16,
  parameter int IDLE_CYCLES = 8,
  parameter int CNT_W       = 16,
  localparam int DLY_W      = dly_width(MAX_DELAY)
) (
  input  logic             pclk,
  input  logic             areset,
  input  logic             din,
  input  logic [DLY_W-1:0] delay,
  input  logic             preset,
  input  logic             inv,
  output logic             rx,
  output logic             start,
  output logic             idle,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int HI_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [HI_W-1:0] HI_MAX = HI_W'(IDLE_CYCLES);

  logic [MAX_DELAY-1:0] line;
  logic [HI_W-1:0]      in_hi;
  logic [HI_W-1:0]      tap_hi;
  logic                 tap;

  // Tap selection: delay 0 bypasses the line so rx is one register behind din.
  always_comb begin
    tap = din;
    for (int k = 1; k <= MAX_DELAY; k++) begin
      if (delay == DLY_W'(k)) begin
        tap = line[k-1];
      end
    end
  end

  // A start edge is a fall at the tap after a full idle run of highs.
  assign start = ~tap && (tap_hi >= HI_MAX);
  assign idle  = din && (in_hi >= HI_MAX) && (&line);

  // Delay line, high-run counters, output register and saturating frame counter.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      line      <= '1;
      rx        <= 1'b1;
      in_hi     <= '0;
      tap_hi    <= '0;
      frame_cnt <= '0;
    end else begin
      if (preset) begin
        line <= '1;
      end else begin
        line[0] <= din;
        for (int k = 1; k < MAX_DELAY; k++) begin
          line[k] <= line[k-1];
        end
      end
      rx <= tap ^ inv;
      if (!din) begin
        in_hi <= '0;
      end else if (in_hi != HI_MAX) begin
        in_hi <= in_hi + 1'b1;
      end
      if (!tap) begin
        tap_hi <= '0;
      end else if (tap_hi != HI_MAX) begin
        tap_hi <= tap_hi + 1'b1;
      end
      if (start && (frame_cnt != '1)) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_link_fabric.sv
// rtl/uart_link_fabric.sv - N-port UART line fabric with routing, delay and fault injection
module uart_link_fabric
  import uart_link_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int MAX_DELAY   = 16,
  parameter int IDLE_CYCLES = 8,
  parameter int INJ_W       = 8,
  parameter int CNT_W       = 16,
  localparam int SEL_W      = sel_width(NUM_PORTS),
  localparam int DLY_W      = dly_width(MAX_DELAY)
) (
  input  logic                       pclk,
  input  logic                       areset,
  input  logic [NUM_PORTS-1:0]       tx,
  output logic [NUM_PORTS-1:0]       rx,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [NUM_PORTS*SEL_W-1:0] cfg_src,
  input  logic [NUM_PORTS*DLY_W-1:0] cfg_delay,
  input  logic                       inj_valid,
  output logic                       inj_ready,
  input  logic [SEL_W-1:0]           inj_port,
  input  logic [INJ_W-1:0]           inj_offset,
  input  logic [INJ_W-1:0]           inj_len,
  output logic                       inj_done,
  output logic [NUM_PORTS*CNT_W-1:0] frame_cnt
);

  localparam logic [SEL_W-1:0] NP_SEL  = SEL_W'(NUM_PORTS);
  localparam logic [DLY_W-1:0] DLY_MAX = DLY_W'(MAX_DELAY);
  localparam int C_W = INJ_W + 1;

  cfg_state_e cfg_state;
  inj_state_e inj_state;

  logic [SEL_W-1:0] act_src  [NUM_PORTS];
  logic [SEL_W-1:0] pend_src [NUM_PORTS];
  logic [DLY_W-1:0] act_dly  [NUM_PORTS];
  logic [DLY_W-1:0] pend_dly [NUM_PORTS];

  logic [NUM_PORTS-1:0] din;
  logic [NUM_PORTS-1:0] start;
  logic [NUM_PORTS-1:0] idle;
  logic [NUM_PORTS-1:0] inv;
  logic                 applying;

  logic [SEL_W-1:0] inj_port_q;
  logic [INJ_W-1:0] inj_off_q;
  logic [INJ_W-1:0] inj_len_q;
  logic [C_W-1:0]   inj_cnt;
  logic [C_W-1:0]   c_now;
  logic [C_W-1:0]   c_off;
  logic [C_W-1:0]   c_end;
  logic             tgt_start;
  logic             tracking;
  logic             win;

  assign applying = (cfg_state == CFG_APPLY);

  // Source mux: unknown selectors and the map-switch cycle both hold the lane idle-high.
  always_comb begin
    din = '1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (!applying && (act_src[i] == SEL_W'(j))) begin
          din[i] = tx[j];
        end
      end
    end
  end

  // Config FSM: a new map is only swapped in once every lane has drained to idle.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      cfg_state <= CFG_IDLE;
      cfg_ready <= 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        act_src[i]  <= SEL_W'(default_route(i, NUM_PORTS));
        act_dly[i]  <= '0;
        pend_src[i] <= '0;
        pend_dly[i] <= '0;
      end
    end else begin
      case (cfg_state)
        CFG_IDLE: begin
          if (cfg_valid) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
              pend_src[i] <= cfg_src[i*SEL_W +: SEL_W];
              pend_dly[i] <= (cfg_delay[i*DLY_W +: DLY_W] > DLY_MAX) ?
                             DLY_MAX : cfg_delay[i*DLY_W +: DLY_W];
            end
            cfg_state <= CFG_WAIT;
            cfg_ready <= 1'b0;
          end
        end
        CFG_WAIT: begin
          if (&idle) begin
            cfg_state <= CFG_APPLY;
          end
        end
        CFG_APPLY: begin
          for (int i = 0; i < NUM_PORTS; i++) begin
            act_src[i] <= pend_src[i];
            act_dly[i] <= pend_dly[i];
          end
          cfg_state <= CFG_IDLE;
          cfg_ready <= 1'b1;
        end
        default: begin
          cfg_state <= CFG_IDLE;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

  // Injector position: cycle 0 is the cycle the target tap shows the start edge.
  always_comb begin
    tgt_start = 1'b0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (inj_port_q == SEL_W'(j)) begin
        tgt_start = start[j];
      end
    end
    c_off    = {1'b0, inj_off_q};
    c_end    = c_off + {1'b0, inj_len_q};
    c_now    = (inj_state == INJ_ARMED) ? '0 : inj_cnt;
    tracking = ((inj_state == INJ_ARMED) && tgt_start) ||
               (inj_state == INJ_OFFSET) || (inj_state == INJ_ACTIVE);
    win      = tracking && !applying && (c_now >= c_off) && (c_now < c_end);
    for (int j = 0; j < NUM_PORTS; j++) begin
      inv[j] = win && (inj_port_q == SEL_W'(j));
    end
  end

  // Injector FSM: one window per request, cancelled silently by a map change.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      inj_state  <= INJ_IDLE;
      inj_ready  <= 1'b1;
      inj_done   <= 1'b0;
      inj_port_q <= '0;
      inj_off_q  <= '0;
      inj_len_q  <= '0;
      inj_cnt    <= '0;
    end else begin
      inj_done <= 1'b0;
      if (inj_state == INJ_IDLE) begin
        if (inj_valid && (inj_port < NP_SEL)) begin
          inj_port_q <= inj_port;
          inj_off_q  <= inj_offset;
          inj_len_q  <= inj_len;
          inj_state  <= INJ_ARMED;
          inj_ready  <= 1'b0;
        end
      end else if (applying) begin
        inj_state <= INJ_IDLE;
        inj_ready <= 1'b1;
      end else if (tracking) begin
        if (c_now == c_end) begin
          inj_state <= INJ_IDLE;
          inj_ready <= 1'b1;
          inj_done  <= 1'b1;
        end else begin
          inj_cnt   <= c_now + 1'b1;
          inj_state <= ((c_now + 1'b1) < c_off) ? INJ_OFFSET : INJ_ACTIVE;
        end
      end
    end
  end

  // One lane per rx port.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
    uart_link_lane #(
      .MAX_DELAY  (MAX_DELAY),
      .IDLE_CYCLES(IDLE_CYCLES),
      .CNT_W      (CNT_W)
    ) u_lane (
      .pclk     (pclk),
      .areset   (areset),
      .din      (din[g]),
      .delay    (act_dly[g]),
      .preset   (applying),
      .inv      (inv[g]),
      .rx       (rx[g]),
      .start    (start[g]),
      .idle     (idle[g]),
      .frame_cnt(frame_cnt[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_uart_link_fabric.sv
// tb/tb_uart_link_fabric.sv - scoreboard bench for uart_link_fabric
module tb_uart_link_fabric;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  logic        pclk = 1'b0;
  logic        areset = 1'b0;
  logic [1:0]  tx = 2'b11;
  logic [1:0]  rx;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [3:0]  cfg_src = '0;
  logic [9:0]  cfg_delay = '0;
  logic        inj_valid = 1'b0;
  logic        inj_ready;
  logic [1:0]  inj_port = '0;
  logic [7:0]  inj_offset = '0;
  logic [7:0]  inj_len = '0;
  logic        inj_done;
  logic [31:0] frame_cnt;

  logic [1:0]  tx_s = 2'b11;
  logic [1:0]  rx_s;
  logic        cfg_ready_s;
  logic        inj_ready_s;
  logic        inj_done_s;
  logic [7:0]  frame_cnt_s;

  ev_t        expq[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [2:0] mon_en = 3'b000;
  logic [1:0] prev_rx = 2'b11;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  uart_link_fabric dut (
    .pclk(pclk), .areset(areset), .tx(tx), .rx(rx),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_src(cfg_src), .cfg_delay(cfg_delay),
    .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_port(inj_port),
    .inj_offset(inj_offset), .inj_len(inj_len), .inj_done(inj_done), .frame_cnt(frame_cnt)
  );

  uart_link_fabric #(.IDLE_CYCLES(2), .CNT_W(4)) dut_sat (
    .pclk(pclk), .areset(areset), .tx(tx_s), .rx(rx_s),
    .cfg_valid(1'b0), .cfg_ready(cfg_ready_s), .cfg_src(4'h0), .cfg_delay(10'h0),
    .inj_valid(1'b0), .inj_ready(inj_ready_s), .inj_port(2'd0),
    .inj_offset(8'd0), .inj_len(8'd0), .inj_done(inj_done_s), .frame_cnt(frame_cnt_s)
  );

  task automatic mon_one(input int k, input logic en, input logic hit, input logic v);
    ev_t e;
    if (hit && en) begin
      n_vec++;
      if (expq.size() == 0) begin
        n_err++;
        $display("FAIL event: unexpected kind %0d val %0d at cycle %0d, required none", k, v, cyc);
      end else begin
        e = expq.pop_front();
        if (e.cyc != cyc || e.kind != k || e.val != int'(v)) begin
          n_err++;
          $display("FAIL event: got kind %0d val %0d cycle %0d, required kind %0d val %0d cycle %0d",
                   k, v, cyc, e.kind, e.val, e.cyc);
        end
      end
    end
  endtask

  // Monitor: every rx transition and inj_done pulse is matched against the queue.
  always @(negedge pclk) begin
    mon_one(0, mon_en[0], rx[0] != prev_rx[0], rx[0]);
    mon_one(1, mon_en[1], rx[1] != prev_rx[1], rx[1]);
    mon_one(2, mon_en[2], inj_done, inj_done);
    prev_rx = rx;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic expect_ev(input int c, input int k, input int v);
    ev_t e;
    e.cyc = c;
    e.kind = k;
    e.val = v;
    expq.push_back(e);
  endtask

  task automatic wait_cfg(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      if (cfg_ready) begin
        at = cyc;
        break;
      end
      tick(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    int at;

    // Reset state
    tick(1);
    check("reset_rx", {30'd0, rx}, 32'd3);
    check("reset_frame_cnt", frame_cnt, 32'd0);
    check("reset_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check("reset_inj_ready", {31'd0, inj_ready}, 32'd1);
    check("reset_inj_done", {31'd0, inj_done}, 32'd0);
    tick(2);
    areset = 1'b1;
    tick(1);
    mon_en = 3'b111;

    // Default crossover
    tick(10);
    t = cyc;
    tx[0] = 1'b0;
    expect_ev(t + 1, 1, 0);
    tick(3);
    tx[0] = 1'b1;
    expect_ev(t + 4, 1, 1);
    tick(3);
    check("crossover_frame_cnt1", {16'd0, frame_cnt[31:16]}, 32'd1);
    check("crossover_frame_cnt0", {16'd0, frame_cnt[15:0]}, 32'd0);

    // Deferred config while tx[0] is toggling
    tick(12);
    t = cyc;
    tx[0] = 1'b0;
    cfg_src = {2'd0, 2'd1};
    cfg_delay = {5'd5, 5'd0};
    cfg_valid = 1'b1;
    expect_ev(t + 1, 1, 0);
    tick(1);
    cfg_valid = 1'b0;
    check("cfg_ready_busy", {31'd0, cfg_ready}, 32'd0);
    tick(1);
    tx[0] = 1'b1;
    expect_ev(t + 3, 1, 1);
    tick(2);
    tx[0] = 1'b0;
    expect_ev(t + 5, 1, 0);
    tick(1);
    tx[0] = 1'b1;
    expect_ev(t + 6, 1, 1);
    tick(7);
    check("cfg_ready_deferred", {31'd0, cfg_ready}, 32'd0);
    wait_cfg(60, at);
    check("cfg_ready_after_idle", {31'd0, at >= t + 14}, 32'd1);
    check("deferred_frame_cnt1", {16'd0, frame_cnt[31:16]}, 32'd2);
    tick(10);
    t = cyc;
    tx[0] = 1'b0;
    expect_ev(t + 6, 1, 0);
    tick(3);
    tx[0] = 1'b1;
    expect_ev(t + 9, 1, 1);
    tick(12);
    check("delay5_frame_cnt1", {16'd0, frame_cnt[31:16]}, 32'd3);

    // Disconnect lane 0
    cfg_src = {2'd0, 2'd2};
    cfg_delay = '0;
    cfg_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
    wait_cfg(80, at);
    check("cfg_disconnect_applied", {31'd0, at >= 0}, 32'd1);
    mon_en[1] = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tx = 2'($urandom_range(0, 3));
      tick(1);
    end
    tx = 2'b11;
    tick(30);
    mon_en[1] = 1'b1;
    check("disconnect_frame_cnt0", {16'd0, frame_cnt[15:0]}, 32'd0);

    // Fault window offset 3, length 2
    inj_port = 2'd1;
    inj_offset = 8'd3;
    inj_len = 8'd2;
    inj_valid = 1'b1;
    tick(1);
    inj_valid = 1'b0;
    check("inj_armed_busy", {31'd0, inj_ready}, 32'd0);
    tick(10);
    t = cyc;
    tx[0] = 1'b0;
    expect_ev(t + 1, 1, 0);
    expect_ev(t + 4, 1, 1);
    expect_ev(t + 6, 1, 0);
    expect_ev(t + 6, 2, 1);
    tick(10);
    tx[0] = 1'b1;
    expect_ev(t + 11, 1, 1);
    tick(2);
    check("inj_ready_after_window", {31'd0, inj_ready}, 32'd1);

    // Zero-length window
    inj_len = 8'd0;
    inj_valid = 1'b1;
    tick(1);
    inj_valid = 1'b0;
    tick(10);
    t = cyc;
    tx[0] = 1'b0;
    expect_ev(t + 1, 1, 0);
    expect_ev(t + 4, 2, 1);
    tick(10);
    tx[0] = 1'b1;
    expect_ev(t + 11, 1, 1);
    tick(2);

    // Config apply while injector is counting its offset
    inj_offset = 8'd100;
    inj_len = 8'd5;
    inj_valid = 1'b1;
    tick(1);
    inj_valid = 1'b0;
    tick(10);
    t = cyc;
    tx[0] = 1'b0;
    expect_ev(t + 1, 1, 0);
    tick(2);
    tx[0] = 1'b1;
    expect_ev(t + 3, 1, 1);
    cfg_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
    wait_cfg(60, at);
    check("apply_during_offset", {31'd0, (at >= 0) && (at < t + 100)}, 32'd1);
    tick(t + 130 - cyc);
    check("inj_ready_after_abort", {31'd0, inj_ready}, 32'd1);

    // Asynchronous reset mid-frame with pending config and armed fault
    tick(10);
    t = cyc;
    tx[0] = 1'b0;
    expect_ev(t + 1, 1, 0);
    cfg_src = {2'd0, 2'd1};
    cfg_delay = {5'd0, 5'd7};
    cfg_valid = 1'b1;
    inj_port = 2'd0;
    inj_offset = 8'd0;
    inj_len = 8'd3;
    inj_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
    inj_valid = 1'b0;
    tick(1);
    check("pre_reset_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    check("pre_reset_inj_ready", {31'd0, inj_ready}, 32'd0);
    #2;
    mon_en = 3'b000;
    areset = 1'b0;
    #1;
    check("async_reset_rx", {30'd0, rx}, 32'd3);
    check("async_reset_frame_cnt", frame_cnt, 32'd0);
    check("async_reset_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check("async_reset_inj_ready", {31'd0, inj_ready}, 32'd1);
    tx[0] = 1'b1;
    tick(3);
    areset = 1'b1;
    tick(2);
    mon_en = 3'b111;
    tick(10);
    t = cyc;
    tx[1] = 1'b0;
    expect_ev(t + 1, 0, 0);
    tick(4);
    tx[1] = 1'b1;
    expect_ev(t + 5, 0, 1);
    tick(3);
    check("post_reset_frame_cnt0", {16'd0, frame_cnt[15:0]}, 32'd1);

    // Frame counter saturation on a 4-bit counter instance
    for (int i = 0; i < 14; i++) begin
      tx_s[1] = 1'b0;
      tick(1);
      tx_s[1] = 1'b1;
      tick(3);
    end
    check("sat_frame_cnt_14", {28'd0, frame_cnt_s[3:0]}, 32'd14);
    for (int i = 0; i < 6; i++) begin
      tx_s[1] = 1'b0;
      tick(1);
      tx_s[1] = 1'b1;
      tick(3);
    end
    check("sat_frame_cnt_max", {28'd0, frame_cnt_s[3:0]}, 32'd15);
    check("sat_frame_cnt1", {28'd0, frame_cnt_s[7:4]}, 32'd0);

    tick(5);
    check("scoreboard_drained", expq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
